// File: rtl/fifo_chk_pkg.sv
// Shared types for the FIFO checker: mismatch codes, arming states and the
// priority encoder that picks the reported code.
package fifo_chk_pkg;

  typedef enum logic [3:0] {
    ERR_NONE   = 4'd0,
    ERR_DATA   = 4'd1,
    ERR_FULL   = 4'd2,
    ERR_EMPTY  = 4'd3,
    ERR_AFULL  = 4'd4,
    ERR_AEMPTY = 4'd5,
    ERR_WR_ACK = 4'd6,
    ERR_OVF    = 4'd7,
    ERR_UDF    = 4'd8
  } err_code_e;

  typedef enum logic [1:0] {
    ARM_IDLE = 2'd0,
    ARM_WAIT = 2'd1,
    ARM_ON   = 2'd2
  } arm_state_e;

  // miss[i] set means field with code i disagrees; lowest code wins.
  function automatic err_code_e pick_code(input logic [8:1] miss);
    err_code_e code;
    code = ERR_NONE;
    if (miss[1])      code = ERR_DATA;
    else if (miss[2]) code = ERR_FULL;
    else if (miss[3]) code = ERR_EMPTY;
    else if (miss[4]) code = ERR_AFULL;
    else if (miss[5]) code = ERR_AEMPTY;
    else if (miss[6]) code = ERR_WR_ACK;
    else if (miss[7]) code = ERR_OVF;
    else if (miss[8]) code = ERR_UDF;
    return code;
  endfunction

endpackage

// File: rtl/fifo_checker_if.sv
// Observed FIFO bus: the FIFO (master) drives everything, the checker (slave)
// only listens.
interface fifo_checker_if #(parameter int DATA_WIDTH = 16);
  // Requests and status flags are valid in the cycle they are sampled; wr_ack,
  // overflow, underflow and data_out answer the request of the previous edge.
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, rd_en, data_in, data_out, full, empty, almostfull,
           almostempty, wr_ack, overflow, underflow
  );

  modport slave (
    input wr_en, rd_en, data_in, data_out, full, empty, almostfull,
          almostempty, wr_ack, overflow, underflow
  );
endinterface

// File: rtl/fifo_chk_model.sv
// Reference FIFO model: pointers, occupancy and (with FIFO_CHECKER_DATA_CHECK_EN)
// a shadow memory holding the words the FIFO should return.
module fifo_chk_model #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    wr_acc,
  output logic                    rd_acc,
  output logic                    ovf,
  output logic                    udf,
  output logic                    exp_full,
  output logic                    exp_empty,
  output logic                    exp_afull,
  output logic                    exp_aempty,
  output logic [DATA_WIDTH-1:0]   rd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // At full a paired request reads only; at empty it writes only.
  always_comb begin
    wr_acc   = wr_en && (count_q != FULL_CNT);
    rd_acc   = rd_en && (count_q != '0);
    ovf      = wr_en && (count_q == FULL_CNT);
    udf      = rd_en && (count_q == '0);
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    count_d  = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign exp_full   = (count_q == FULL_CNT);
  assign exp_empty  = (count_q == '0);
  assign exp_afull  = (count_q == AFULL_CNT);
  assign exp_aempty = (count_q == CW'(1));

`ifdef FIFO_CHECKER_DATA_CHECK_EN
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign rd_data = mem_q[rd_ptr_q];
`else
  logic unused_data_in;
  assign unused_data_in = ^data_in;
  assign rd_data        = '0;
`endif

endmodule

// File: rtl/fifo_checker.sv
// FIFO protocol checker: compares an observed FIFO against fifo_chk_model and
// reports mismatches. Define FIFO_CHECKER_DATA_CHECK_EN to also check data_out.
module fifo_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  fifo_checker_if.slave          bus,
  output logic                   err_valid,
  output logic [3:0]             err_code,
  output logic [3:0]             first_err_code,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic [CNT_WIDTH-1:0]   ok_count,
  output arm_state_e             dbg_arm_state,
  output logic [$clog2(DEPTH):0] dbg_count
);
  logic mdl_wr_acc, mdl_rd_acc, mdl_ovf, mdl_udf;
  logic mdl_full, mdl_empty, mdl_afull, mdl_aempty;
  logic [DATA_WIDTH-1:0] mdl_rd_data;

  fifo_chk_model #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_model (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .data_in    (bus.data_in),
    .count      (dbg_count),
    .wr_acc     (mdl_wr_acc),
    .rd_acc     (mdl_rd_acc),
    .ovf        (mdl_ovf),
    .udf        (mdl_udf),
    .exp_full   (mdl_full),
    .exp_empty  (mdl_empty),
    .exp_afull  (mdl_afull),
    .exp_aempty (mdl_aempty),
    .rd_data    (mdl_rd_data)
  );

  arm_state_e arm_state_q, arm_state_d;
  logic armed;
  logic exp_wr_ack_q, exp_ovf_q, exp_udf_q;
  logic data_miss;
  logic [8:1] miss;
  err_code_e cmp_code;
  logic err_valid_q, err_valid_d;
  err_code_e err_code_q, err_code_d, first_q, first_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, ok_cnt_q, ok_cnt_d;

  // Comparisons start only after the FIFO has had two edges out of reset.
  always_comb begin
    arm_state_d = arm_state_q;
    case (arm_state_q)
      ARM_IDLE: arm_state_d = ARM_WAIT;
      ARM_WAIT: arm_state_d = ARM_ON;
      default:  arm_state_d = ARM_ON;
    endcase
  end
  assign armed = (arm_state_q == ARM_ON);

`ifdef FIFO_CHECKER_DATA_CHECK_EN
  logic                  exp_rd_q;
  logic [DATA_WIDTH-1:0] exp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_rd_q   <= 1'b0;
      exp_data_q <= '0;
    end else begin
      exp_rd_q   <= mdl_rd_acc;
      exp_data_q <= mdl_rd_data;
    end
  end
  assign data_miss = exp_rd_q && (bus.data_out != exp_data_q);
`else
  logic unused_data;
  assign unused_data = ^{bus.data_out, mdl_rd_data, mdl_rd_acc};
  assign data_miss   = 1'b0;
`endif

  always_comb begin
    miss     = '0;
    miss[1]  = data_miss;
    miss[2]  = bus.full        != mdl_full;
    miss[3]  = bus.empty       != mdl_empty;
    miss[4]  = bus.almostfull  != mdl_afull;
    miss[5]  = bus.almostempty != mdl_aempty;
    miss[6]  = bus.wr_ack      != exp_wr_ack_q;
    miss[7]  = bus.overflow    != exp_ovf_q;
    miss[8]  = bus.underflow   != exp_udf_q;
    cmp_code = armed ? pick_code(miss) : ERR_NONE;
  end

  // clr only touches the statistics; it overrides any same-cycle increment.
  always_comb begin
    err_valid_d = (cmp_code != ERR_NONE);
    err_code_d  = cmp_code;
    first_d     = first_q;
    err_cnt_d   = err_cnt_q;
    ok_cnt_d    = ok_cnt_q;
    if (armed) begin
      if (cmp_code != ERR_NONE) begin
        if (err_cnt_q != '1)     err_cnt_d = err_cnt_q + 1'b1;
        if (first_q == ERR_NONE) first_d   = cmp_code;
      end else if (ok_cnt_q != '1) begin
        ok_cnt_d = ok_cnt_q + 1'b1;
      end
    end
    if (clr) begin
      first_d   = ERR_NONE;
      err_cnt_d = '0;
      ok_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_state_q  <= ARM_IDLE;
      exp_wr_ack_q <= 1'b0;
      exp_ovf_q    <= 1'b0;
      exp_udf_q    <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      first_q      <= ERR_NONE;
      err_cnt_q    <= '0;
      ok_cnt_q     <= '0;
    end else begin
      arm_state_q  <= arm_state_d;
      exp_wr_ack_q <= mdl_wr_acc;
      exp_ovf_q    <= mdl_ovf;
      exp_udf_q    <= mdl_udf;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      first_q      <= first_d;
      err_cnt_q    <= err_cnt_d;
      ok_cnt_q     <= ok_cnt_d;
    end
  end

  assign err_valid      = err_valid_q;
  assign err_code       = err_code_q;
  assign first_err_code = first_q;
  assign err_count      = err_cnt_q;
  assign ok_count       = ok_cnt_q;
  assign dbg_arm_state  = arm_state_q;

endmodule

// File: tb/tb_fifo_checker.sv
// Bench for fifo_checker: a behavioural FIFO drives the observed bus with
// optional injected faults; expected error codes are queued and matched.
module tb_fifo_checker;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  fifo_checker_if #(.DATA_WIDTH(DW)) bus ();

  logic          err_valid;
  logic [3:0]    err_code;
  logic [3:0]    first_err_code;
  logic [CW-1:0] err_count;
  logic [CW-1:0] ok_count;
  logic [1:0]    dbg_arm_state;
  logic [3:0]    dbg_count;

  fifo_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .bus            (bus),
    .err_valid      (err_valid),
    .err_code       (err_code),
    .first_err_code (first_err_code),
    .err_count      (err_count),
    .ok_count       (ok_count),
    .dbg_arm_state  (dbg_arm_state),
    .dbg_count      (dbg_count)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  logic [DW-1:0] f_q[$];
  bit inj_ovf_zero   = 1'b0;
  bit inj_empty_zero = 1'b0;
  bit inj_data       = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every err_valid pulse must match the queue head
  always @(negedge clk) begin
    if (!rst && err_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_err: got code %0d, want no error", err_code);
      end else begin
        mon_exp = exp_q.pop_front();
        check("err_code", int'(err_code), int'(mon_exp));
      end
    end
  end

  // driver: one FIFO cycle; flags from pre-edge occupancy, responses after
  task automatic step(input bit wr, input bit rd, input logic [DW-1:0] din);
    int c;
    c               = f_q.size();
    bus.wr_en       = wr;
    bus.rd_en       = rd;
    bus.data_in     = din;
    bus.full        = (c == DEPTH);
    bus.empty       = (c == 0) && !inj_empty_zero;
    bus.almostfull  = (c == DEPTH - 1);
    bus.almostempty = (c == 1);
    @(posedge clk);
    #1;
    if (rst) begin
      f_q.delete();
      bus.wr_ack    = 1'b0;
      bus.overflow  = 1'b0;
      bus.underflow = 1'b0;
    end else begin
      bus.wr_ack    = wr && (c < DEPTH);
      bus.overflow  = wr && (c == DEPTH);
      bus.underflow = rd && (c == 0);
      if (rd && c > 0) begin
        bus.data_out = f_q.pop_front();
        if (inj_data) bus.data_out = 16'hDEAD;
      end
      if (wr && c < DEPTH) f_q.push_back(din);
      if (inj_ovf_zero) bus.overflow = 1'b0;
    end
    inj_empty_zero = 1'b0;
    inj_ovf_zero   = 1'b0;
    inj_data       = 1'b0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic clr_step();
    clr = 1'b1;
    step(1'b0, 1'b0, '0);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    f_q.delete();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0; bus.data_out = '0;
    bus.full = 1'b0; bus.empty = 1'b1; bus.almostfull = 1'b0; bus.almostempty = 1'b0;
    bus.wr_ack = 1'b0; bus.overflow = 1'b0; bus.underflow = 1'b0;
    #1;
    check("rst_err_valid", int'(err_valid), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_first_err", int'(first_err_code), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_ok_count", int'(ok_count), 0);
    check("rst_count", int'(dbg_count), 0);
    check("rst_arm_state", int'(dbg_arm_state), 0);
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    clr = 1'b0;
    do_reset();
    idle(2);

    // 8 writes then 8 reads, clean FIFO
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i));
    check("fill_count", int'(dbg_count), 8);
    idle(1);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, '0);
    idle(1);
    check("drain_err_count", int'(err_count), 0);
    check("drain_count", int'(dbg_count), 0);

    // clean cycles counted after clear
    clr_step();
    idle(5);
    check("ok_after_clr", int'(ok_count), 5);
    check("err_after_clr", int'(err_count), 0);
    check("first_after_clr", int'(first_err_code), 0);

    // overflow expected but FIFO reports none
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(16'h0010 + i));
    exp_q.push_back(4'd7);
    inj_ovf_zero = 1'b1;
    step(1'b1, 1'b0, 16'h0099);
    idle(2);
    check("ovf_first_err", int'(first_err_code), 7);
    check("ovf_err_count", int'(err_count), 1);
    check("ovf_count", int'(dbg_count), 8);

    // paired request at full reads only
    step(1'b1, 1'b1, 16'h0077);
    check("pair_full_count", int'(dbg_count), 7);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
    idle(1);
    check("pair_drain_count", int'(dbg_count), 0);
    check("pair_err_count", int'(err_count), 1);

    // legal underflow, then empty flag wrongly low
    step(1'b0, 1'b1, '0);
    idle(1);
    check("udf_err_count", int'(err_count), 1);
    exp_q.push_back(4'd3);
    inj_empty_zero = 1'b1;
    idle(3);
    check("empty_err_count", int'(err_count), 2);
    check("empty_first_sticky", int'(first_err_code), 7);

    // paired request at empty writes only
    step(1'b1, 1'b1, 16'h00AA);
    check("pair_empty_count", int'(dbg_count), 1);
    step(1'b0, 1'b1, '0);
    idle(1);
    check("pair_empty_drain", int'(dbg_count), 0);
    check("pair_empty_err", int'(err_count), 2);

    // corrupted read data
    step(1'b1, 1'b0, 16'h1234);
`ifdef FIFO_CHECKER_DATA_CHECK_EN
    exp_q.push_back(4'd1);
`endif
    inj_data = 1'b1;
    step(1'b0, 1'b1, '0);
    idle(2);
`ifdef FIFO_CHECKER_DATA_CHECK_EN
    check("data_err_count", int'(err_count), 3);
`else
    check("data_err_count", int'(err_count), 2);
`endif

    // clear mid-operation keeps the model occupancy
    step(1'b1, 1'b0, 16'h000A);
    step(1'b1, 1'b0, 16'h000B);
    step(1'b1, 1'b0, 16'h000C);
    clr_step();
    check("clr_keeps_count", int'(dbg_count), 3);
    check("clr_err_count", int'(err_count), 0);
    check("clr_first_err", int'(first_err_code), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
    idle(1);
    check("clr_ok_count", int'(ok_count), 4);
    exp_q.push_back(4'd3);
    inj_empty_zero = 1'b1;
    idle(3);
    check("relatch_first", int'(first_err_code), 3);
    check("relatch_err_count", int'(err_count), 1);

    // reset in the middle of traffic
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, DW'(16'h0050 + i));
    check("pre_rst_count", int'(dbg_count), 5);
    do_reset();
    idle(6);
    check("post_rst_ok", int'(ok_count), 4);
    check("post_rst_err", int'(err_count), 0);
    check("post_rst_first", int'(first_err_code), 0);

    check("pending_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
